// File: rtl/iwanna_soc_debug_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG host driver.
// Holds the sequencer state encoding, default widths and the debug slave IR codes.
package iwanna_soc_debug_jtag_pkg;

  localparam int JTAG_DR_WIDTH = 38;
  localparam int JTAG_IR_WIDTH = 2;

  localparam logic [JTAG_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_TRACE     = 2'd1;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
  localparam logic [JTAG_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } jtag_state_e;

endpackage

// File: rtl/iwanna_soc_debug_jtag_tck_gen.sv
// Divided test-clock generator: TCK_DIV clk cycles per tck half-period while run is high.
// rise_evt/fall_evt flag the clk edge on which tck is about to go high/low.
module iwanna_soc_debug_jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic vji_tck,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tck_q;
  logic          wrap;

  assign wrap     = run && (cnt_q == CNT_LAST);
  assign rise_evt = wrap && !tck_q;
  assign fall_evt = wrap && tck_q;
  assign vji_tck  = tck_q;

  // Idle parks tck low with the counter cleared so every transaction starts phase-aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (!run) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (wrap) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/iwanna_soc_debug_jtag_host.sv
// Host-side virtual-JTAG driver: one IR/DR command per transaction, sequenced
// UIR, CDR, SDR x DR_WIDTH, UDR, RTI on a divided tck, returning the captured tdo word.
//
//   state | meaning
//   IDLE  | ready for a command, rti high
//   UIR   | update-IR flag for one tck period
//   CDR   | capture-DR flag for one tck period
//   SDR   | shift DR_WIDTH bits, tdi out on falls, tdo in on rises
//   UDR   | update-DR flag for one tck period
//   RTI   | run-test-idle for one tck period
//   RESP  | one clk cycle, present captured word
module iwanna_soc_debug_jtag_host
  import iwanna_soc_debug_jtag_pkg::*;
#(
  parameter int DR_WIDTH = JTAG_DR_WIDTH,
  parameter int IR_WIDTH = JTAG_IR_WIDTH,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  jtag_state_e         state_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic [DR_WIDTH-1:0] rsp_data_q;
  logic [DR_WIDTH-1:0] tx_q;
  logic [DR_WIDTH-1:0] cap_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic                tdi_q;
  logic                uir_q, cdr_q, sdr_q, udr_q, rti_q;
  logic                run;
  logic                rise_evt;
  logic                fall_evt;

  assign run = (state_q != ST_IDLE) && (state_q != ST_RESP);

  iwanna_soc_debug_jtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .vji_tck  (vji_tck),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      tx_q        <= '0;
      cap_q       <= '0;
      bit_cnt_q   <= '0;
      ir_q        <= '0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      if (rise_evt && state_q == ST_SDR) begin
        cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
      end
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q     <= ST_UIR;
            cmd_ready_q <= 1'b0;
            ir_q        <= cmd_ir;
            tx_q        <= cmd_data;
            uir_q       <= 1'b1;
            rti_q       <= 1'b0;
          end
        end
        ST_UIR: begin
          if (fall_evt) begin
            state_q <= ST_CDR;
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
          end
        end
        ST_CDR: begin
          if (fall_evt) begin
            state_q   <= ST_SDR;
            cdr_q     <= 1'b0;
            sdr_q     <= 1'b1;
            tdi_q     <= tx_q[0];
            tx_q      <= {1'b0, tx_q[DR_WIDTH-1:1]};
            bit_cnt_q <= BIT_LAST;
          end
        end
        ST_SDR: begin
          // Down-count remaining bits; the fall at terminal count ends the shift.
          if (fall_evt) begin
            if (bit_cnt_q == '0) begin
              state_q <= ST_UDR;
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              tdi_q   <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
              tdi_q     <= tx_q[0];
              tx_q      <= {1'b0, tx_q[DR_WIDTH-1:1]};
            end
          end
        end
        ST_UDR: begin
          if (fall_evt) begin
            state_q <= ST_RTI;
            udr_q   <= 1'b0;
            rti_q   <= 1'b1;
          end
        end
        ST_RTI: begin
          if (fall_evt) begin
            state_q     <= ST_RESP;
            ir_q        <= '0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap_q;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vji_tdi   = tdi_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = uir_q;
  assign vji_cdr   = cdr_q;
  assign vji_sdr   = sdr_q;
  assign vji_udr   = udr_q;
  assign vji_rti   = rti_q;

endmodule

// File: doc/iwanna_soc_debug_jtag_host.md
# iwanna_soc_debug_jtag_host

Synthesizable host-side driver for the Nios II debug slave's virtual-JTAG port. It accepts one IR/DR command per transaction and generates the virtual-JTAG control sequence UIR, CDR, SDR×DR_WIDTH, UDR, RTI on a divided tck. It shifts command data out on tdi, captures tdo, and returns the captured word. It sits between a system-clock command source (bench sequencer or on-chip scrubber) and the debug slave's tck-domain signals, replacing the JTAG hub in simulation and bring-up builds.

## Interface
- DR_WIDTH, 38, debug slave shift-register length
- IR_WIDTH, 2, virtual IR width
- TCK_DIV, 4, clk cycles per tck half-period (≥1)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_ir  in  IR_WIDTH  IR value for this transaction
- cmd_data  in  DR_WIDTH  DR value, shifted LSB first
- rsp_valid  out  1  one-cycle pulse, rsp_data valid
- rsp_data  out  DR_WIDTH  captured tdo word; first-captured bit at bit 0
- vji_tck  out  1  divided test clock
- vji_tdi  out  1  serial data to slave
- vji_tdo  in  1  serial data from slave
- vji_ir_in  out  IR_WIDTH  IR presented to slave
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual-state flags
- vji_rti  out  1  run-test-idle flag

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
- Reset values: cmd_ready=1, vji_rti=1. All other outputs are 0, including rsp_data. tck is low and the half-period counter is 0.
- IDLE: cmd_valid&cmd_ready latches cmd_ir into vji_ir_in and cmd_data into the tx shifter, then enters UIR.
- tck: runs only outside IDLE/RESP. The counter wraps every TCK_DIV cycles and toggles tck.
  - Wrap with tck low is a rise event.
  - Wrap with tck high is a fall event.
- State advances happen only on fall events. Each of UIR, CDR, UDR and RTI lasts one tck period. SDR lasts DR_WIDTH periods, counted by a bit counter.
- Flags: exactly one of uir/cdr/sdr/udr is high in its matching state. vji_rti is high in RTI and IDLE.
- vji_ir_in: stable at the latched value from UIR through RTI. It returns to 0 in IDLE.
- tdi:
  - On the fall event entering SDR, tdi takes data[0].
  - Each later fall event in SDR shifts to the next bit.
  - tdi is 0 in all other states.
- Capture: on each rise event in SDR, cap shifts right: cap <= {vji_tdo, cap[DR_WIDTH-1:1]}.
- The fall event ending RTI enters RESP. RESP lasts one clk cycle: rsp_data takes cap and rsp_valid=1. The next state is IDLE.
- rsp_data holds its value until the next RESP.
- cmd_valid outside IDLE is ignored. There is no response backpressure.
- Reset mid-transaction: all state returns to reset values asynchronously. No rsp_valid is produced.

## Timing
- A tck period is 2·TCK_DIV clk cycles. A transaction is DR_WIDTH+4 tck periods.
- rsp_valid is high in the cycle 2·TCK_DIV·(DR_WIDTH+4)+1 clk edges after the accepting edge. With defaults this is 337.
- cmd_ready drops the cycle after acceptance and returns in the cycle after rsp_valid. The minimum command spacing is therefore 2·TCK_DIV·(DR_WIDTH+4)+2 cycles.
- Flags, tdi and ir_in change only coincident with a tck fall. They are stable across every tck rise, so the slave samples them cleanly.
- TCK_DIV=1: tck toggles every clk cycle and all rules still hold.

## Structure
- Shared package iwanna_soc_debug_jtag_pkg holds:
  - the state enum;
  - DR/IR width constants;
  - IR codes (0 ocimem, 1 trace, 2 break, 3 tracectrl).
- Sub-module iwanna_soc_debug_jtag_tck_gen contains the half-period counter and tck register. Its inputs are run and clk/reset_n. Its outputs are vji_tck, rise_evt and fall_evt.
- The top level contains the FSM, bit counter, tx shifter and capture register.

## Test plan
- Reset, then idle 20 cycles: cmd_ready=1, vji_rti=1, tck static low, all flags and tdi 0.
- cmd_ir=2, cmd_data=38'h25_A5A5_A5A5, tdo looped from tdi through one tck-rise register: at cycle 337 rsp_valid=1 and rsp_data equals cmd_data; uir/cdr/udr each high for exactly 8 cycles; sdr high for 304.
- tdo tied 1: rsp_data=38'h3F_FFFF_FFFF. tdo tied 0: rsp_data=0. Check ir_in=cmd_ir from UIR through RTI.
- cmd_valid held high continuously: exactly one acceptance per transaction, with spacing 338 cycles; second command's data does not corrupt the first.
- reset_n asserted at cycle 150 of a transaction: outputs go to reset values immediately, no rsp_valid, and the next command completes normally.
- TCK_DIV=1 build: tck toggles every cycle and rsp_valid arrives at cycle 85 after accept.
